// File: rtl/parity_frame_sequencer_pkg.sv
// parity_frame_sequencer_pkg: state encoding, default width and phase sequencing shared by the sequencer and its bench.
package parity_frame_sequencer_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

`ifdef STOP_BIT_EN
    localparam state_t ST_FINAL = ST_STOP;
`else
    localparam state_t ST_FINAL = ST_PAR;
`endif

    // Phase following a completed live bit; the final phase always returns to IDLE.
    function automatic state_t next_phase(state_t s, logic last_data);
        return (s == ST_SHIFT) ? (last_data ? ST_PAR : ST_SHIFT) :
               (s == ST_PAR && ST_FINAL == ST_STOP) ? ST_STOP : ST_IDLE;
    endfunction

endpackage

// File: rtl/parity_accumulator.sv
// parity_accumulator: XOR register loaded with the parity seed on clr and folded with each enabled bit.
module parity_accumulator (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic init,
    input  logic en,
    input  logic bit_in,
    output logic acc
);

    always_ff @(posedge clk) begin
        if (rst)
            acc <= 1'b0;
        else if (clr)
            acc <= init;
        else if (en)
            acc <= acc ^ bit_in;
    end

endmodule

// File: rtl/parity_frame_sequencer.sv
// parity_frame_sequencer: frames a parallel word as LSB-first serial bits plus parity; defining STOP_BIT_EN
// appends a stop bit.
module parity_frame_sequencer
    import parity_frame_sequencer_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    input  logic              hold,
    output logic              serial_out,
    output logic              serial_en,
    output logic              parity_bit,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W);

    state_t            state, state_n;
    logic [CNT_W-1:0]  bit_cnt, cnt_n;
    logic [DATA_W-1:0] sreg, sreg_n;
    logic              out_n, en_n, done_n;
    logic              accept, acc_en, acc, par_now, last_data, live;

    assign ready      = (state == ST_IDLE) & ~rst;
    assign busy       = state != ST_IDLE;
    assign parity_bit = acc;

    parity_accumulator u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .init   (ODD_PARITY),
        .en     (acc_en),
        .bit_in (serial_out),
        .acc    (acc)
    );

    // state/bit_cnt/sreg name the slot shown this cycle; a slot only advances after it was live,
    // so a held slot is replayed with serial_en low until hold drops.
    always_comb begin
        accept    = valid & ready;
        acc_en    = serial_en & (state == ST_SHIFT);
        par_now   = acc ^ (acc_en & serial_out);
        last_data = bit_cnt == CNT_W'(DATA_W - 1);
        state_n   = state;
        cnt_n     = bit_cnt;
        sreg_n    = sreg;
        if (accept) begin
            state_n = ST_SHIFT;
            cnt_n   = '0;
            sreg_n  = data_in;
        end else if (state != ST_IDLE && serial_en) begin
            state_n = next_phase(state, last_data);
            if (state == ST_SHIFT && !last_data) begin
                cnt_n  = bit_cnt + CNT_W'(1);
                sreg_n = sreg >> 1;
            end
        end
        live   = (state_n != ST_IDLE) & (~hold | accept);
        en_n   = live;
        done_n = live & (state_n == ST_FINAL);
        out_n  = (state_n == ST_IDLE) ? 1'b0 :
                 !live                ? serial_out :
                 (state_n == ST_SHIFT) ? sreg_n[0] :
                 (state_n == ST_PAR)   ? par_now : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            sreg       <= '0;
            serial_out <= 1'b0;
            serial_en  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= cnt_n;
            sreg       <= sreg_n;
            serial_out <= out_n;
            serial_en  <= en_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_parity_frame_sequencer.sv
// tb_parity_frame_sequencer: drives an even- and an odd-parity instance with shared stimulus and checks both
// against a slot-queue model of the frame; STOP_BIT_EN selects the stop-bit frame length.
module tb_parity_frame_sequencer;

    localparam int DATA_W = 8;
`ifdef STOP_BIT_EN
    localparam int SLOTS = DATA_W + 2;
`else
    localparam int SLOTS = DATA_W + 1;
`endif
    localparam int PERIOD = SLOTS + 1;

    typedef struct {
        logic [7:0] data;
        logic       par_even;
        logic       par_odd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1, valid = 1'b0, hold = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic ready[2], serial_out[2], serial_en[2], parity_bit[2], busy[2], done[2];
    int checks = 0, failures = 0;

    // model state: queue of pending slots (0/1 data bit, 2 parity, 3 stop)
    int   q[$];
    logic [7:0] cur = '0;
    bit   in_frame = 0, out_chk = 0, par_chk = 0, last_acc = 0;
    logic prev[2] = '{1'b0, 1'b0};
    logic e_out[2] = '{1'b0, 1'b0};
    logic e_par[2] = '{1'b0, 1'b0};
    logic e_en = 1'b0, e_done = 1'b0, e_busy = 1'b0;

    always #5 clk = ~clk;

    parity_frame_sequencer #(.DATA_W(DATA_W), .ODD_PARITY(1'b0)) u_even (
        .clk(clk), .rst(rst), .data_in(data_in), .valid(valid), .ready(ready[0]), .hold(hold),
        .serial_out(serial_out[0]), .serial_en(serial_en[0]), .parity_bit(parity_bit[0]),
        .busy(busy[0]), .done(done[0])
    );

    parity_frame_sequencer #(.DATA_W(DATA_W), .ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .rst(rst), .data_in(data_in), .valid(valid), .ready(ready[1]), .hold(hold),
        .serial_out(serial_out[1]), .serial_en(serial_en[1]), .parity_bit(parity_bit[1]),
        .busy(busy[1]), .done(done[1])
    );

    task automatic chk(input string n, input int i, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", n, i, a, e, $time);
        end
    endtask

    task automatic set_idle();
        e_en = 0; e_done = 0; e_busy = 0; out_chk = 0; par_chk = 1;
    endtask

    task automatic pop_live();
        int s = q.pop_front();
        e_en = 1; e_busy = 1; e_done = (q.size() == 0); out_chk = 1; par_chk = (s >= 2);
        for (int i = 0; i < 2; i++) begin
            e_out[i] = (s == 2) ? ((^cur) ^ i[0]) : (s == 3) ? 1'b1 : s[0];
            prev[i]  = e_out[i];
            if (s == 2) e_par[i] = e_out[i];
        end
    endtask

    // One clock: drive inputs, check ready, advance model at the edge, check registered outputs.
    task automatic tick(input logic r, input logic v, input logic h, input logic [7:0] d);
        @(negedge clk);
        rst = r; valid = v; hold = h; data_in = d;
        #1;
        for (int i = 0; i < 2; i++) chk("ready", i, ready[i], !r && !in_frame);
        last_acc = v && !r && !in_frame;
        @(posedge clk);
        if (r) begin
            q.delete(); in_frame = 0; set_idle(); out_chk = 1;
            e_out = '{1'b0, 1'b0}; prev = '{1'b0, 1'b0}; e_par = '{1'b0, 1'b0};
        end else if (!in_frame) begin
            if (v) begin
                cur = d;
                for (int k = 0; k < DATA_W; k++) q.push_back(int'(d[k]));
                q.push_back(2);
`ifdef STOP_BIT_EN
                q.push_back(3);
`endif
                in_frame = 1;
                pop_live();
            end else set_idle();
        end else if (q.size() == 0) begin
            in_frame = 0; set_idle();
        end else if (h) begin
            e_en = 0; e_done = 0; e_busy = 1; out_chk = 1; par_chk = 0; e_out = prev;
        end else pop_live();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("serial_en", i, serial_en[i], e_en);
            chk("done", i, done[i], e_done);
            chk("busy", i, busy[i], e_busy);
            if (out_chk) chk("serial_out", i, serial_out[i], e_out[i]);
            if (par_chk) chk("parity_bit", i, parity_bit[i], e_par[i]);
        end
    endtask

    // Accept one word and run it to done; hold is asserted on ticks [hold_at, hold_at+hold_len).
    task automatic send_frame(input logic [7:0] d, input int hold_at, input int hold_len,
                              output int done_at, output logic [7:0] bits, output int stalls);
        int n = 0;
        int w = 0;
        done_at = -1; bits = '0; stalls = 0;
        while (in_frame && w < 2 * PERIOD) begin
            tick(0, 0, 0, 8'h00);
            w++;
        end
        for (int k = 0; k < 4 * PERIOD; k++) begin
            tick(0, k == 0, k >= hold_at && k < hold_at + hold_len, k == 0 ? d : 8'h00);
            if (serial_en[0] && n < DATA_W) begin
                bits[n] = serial_out[0];
                n++;
            end
            if (!serial_en[0] && busy[0]) stalls++;
            if (done[0]) begin
                done_at = k;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        logic [7:0] words[3];
        logic [7:0] bits;
        int da, st, dones, sent;
        int done_t[3];
        vecs[0] = '{8'hA5, 1'b0, 1'b1};
        vecs[1] = '{8'h07, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1};
        vecs[4] = '{8'h3C, 1'b0, 1'b1};
        vecs[5] = '{8'h81, 1'b0, 1'b1};
        vecs[6] = '{8'h01, 1'b1, 1'b0};
        words[0] = 8'h11; words[1] = 8'h96; words[2] = 8'hE7;

        tick(1, 0, 0, 8'h00);
        tick(1, 1, 1, 8'hFF);
        tick(0, 0, 1, 8'h00);

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, 0, 0, da, bits, st);
            chk("vec_bits", i, bits, vecs[i].data);
            chk("vec_done_at", i, da, SLOTS - 1);
            chk("vec_par_even", i, parity_bit[0], vecs[i].par_even);
            chk("vec_par_odd", i, parity_bit[1], vecs[i].par_odd);
            tick(0, 0, 0, 8'h00);
        end

        send_frame(8'h3C, 3, 3, da, bits, st);
        chk("hold_bits", 0, bits, 8'h3C);
        chk("hold_done_at", 0, da, SLOTS - 1 + 3);
        chk("hold_stalls", 0, st, 3);

        send_frame(8'hC3, SLOTS - 1, 2, da, bits, st);
        chk("hold_final_done_at", 0, da, SLOTS + 1);
        chk("hold_final_stalls", 0, st, 2);

        send_frame(8'h5A, 0, 2, da, bits, st);
        chk("hold_idle_done_at", 0, da, SLOTS);
        chk("hold_idle_stalls", 0, st, 1);
        chk("hold_idle_bits", 0, bits, 8'h5A);
        tick(0, 0, 0, 8'h00);

        sent = 0; dones = 0;
        for (int k = 0; k < 3 * PERIOD + 4; k++) begin
            tick(0, sent < 3, 0, words[sent < 3 ? sent : 0]);
            if (last_acc) sent++;
            if (done[0]) begin
                if (dones < 3) done_t[dones] = k;
                dones++;
            end
        end
        chk("stream_dones", 0, dones, 3);
        chk("stream_spacing", 0, done_t[1] - done_t[0], PERIOD);
        chk("stream_spacing", 1, done_t[2] - done_t[1], PERIOD);

        tick(0, 1, 0, 8'h5A);
        for (int k = 1; k <= 4; k++) tick(0, 0, 0, 8'h00);
        chk("abort_bit4", 0, serial_out[0], 1'b1);
        tick(1, 0, 0, 8'h00);
        chk("abort_busy", 0, busy[0], 1'b0);
        chk("abort_par_odd", 0, parity_bit[1], 1'b0);
        tick(0, 0, 0, 8'h00);
        send_frame(8'h81, 0, 0, da, bits, st);
        chk("after_abort_bits", 0, bits, 8'h81);
        chk("after_abort_par", 0, parity_bit[0], 1'b0);
        chk("after_abort_done_at", 0, da, SLOTS - 1);

        for (int k = 0; k < 600; k++)
            tick($urandom_range(63) == 0, $urandom_range(1) == 1, $urandom_range(3) == 0,
                 8'($urandom));
        for (int k = 0; k < PERIOD + 2; k++) tick(0, 0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
